// File: rtl/mem_iq_issue_scheduler_if.sv
// rtl/mem_iq_issue_scheduler_if.sv - LSU issue port handshake between scheduler and load/store unit
interface mem_iq_issue_scheduler_if #(
    parameter int MEM_IQ_WIDTH = 3
);
    logic                    issue_valid;
    logic [MEM_IQ_WIDTH-1:0] issue_idx;
    logic                    issue_is_store;
    logic                    issue_ready;

    modport master (
        output issue_valid,
        output issue_idx,
        output issue_is_store,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_idx,
        input  issue_is_store,
        output issue_ready
    );
endinterface

// File: rtl/mem_iq_issue_scheduler.sv
// rtl/mem_iq_issue_scheduler.sv - store-first, starvation-aware issue scheduler for the 8-entry MEM issue queue
module mem_iq_issue_scheduler #(
    parameter int MEM_IQ_NUM   = 8,
    parameter int MEM_IQ_WIDTH = 3,
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [MEM_IQ_NUM-1:0]      entry_alloc,
    input  logic [MEM_IQ_NUM-1:0]      entry_ready,
    input  logic [MEM_IQ_NUM-1:0]      entry_is_store,
    input  logic                       sb_full,
    input  logic                       issue_lock,
    mem_iq_issue_scheduler_if.master   issue
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [MEM_IQ_WIDTH-1:0]             idx_q;
    logic                                is_store_q;
    logic [MEM_IQ_NUM-1:0][CNT_W-1:0]    wait_cnt;
    logic [MEM_IQ_NUM-1:0][CNT_W-1:0]    wait_cnt_d;

    logic                                offer_valid;
    logic                                fire;
    logic                                load_en;
    logic [MEM_IQ_NUM-1:0]               eligible;
    logic [MEM_IQ_NUM-1:0]               starving;
    logic                                sel_valid;
    logic [MEM_IQ_WIDTH-1:0]             sel_idx;
    logic                                sel_starve_hit;
    logic                                sel_store_hit;
    logic [MEM_IQ_WIDTH-1:0]             starve_idx;
    logic [MEM_IQ_WIDTH-1:0]             store_idx;
    logic [MEM_IQ_WIDTH-1:0]             load_idx;

    assign offer_valid          = (state_q == S_OFFER);
    assign fire                 = offer_valid & issue.issue_ready;
    assign issue.issue_valid    = offer_valid;
    assign issue.issue_idx      = idx_q;
    assign issue.issue_is_store = is_store_q;

    // The held offer is excluded so the entry firing this cycle is never re-picked
    // before the IQ drops its ready bit.
    always_comb begin
        for (int i = 0; i < MEM_IQ_NUM; i++) begin
            eligible[i] = entry_ready[i]
                        & ~(offer_valid && (idx_q == MEM_IQ_WIDTH'(i)))
                        & ~(entry_is_store[i] & sb_full);
            starving[i] = eligible[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        sel_starve_hit = 1'b0;
        sel_store_hit  = 1'b0;
        starve_idx     = '0;
        store_idx      = '0;
        load_idx       = '0;
        for (int i = MEM_IQ_NUM - 1; i >= 0; i--) begin
            if (starving[i]) begin
                sel_starve_hit = 1'b1;
                starve_idx     = MEM_IQ_WIDTH'(i);
            end
            if (eligible[i] && entry_is_store[i]) begin
                sel_store_hit = 1'b1;
                store_idx     = MEM_IQ_WIDTH'(i);
            end
            if (eligible[i] && !entry_is_store[i]) begin
                load_idx = MEM_IQ_WIDTH'(i);
            end
        end
        sel_valid = |eligible;
        if (sel_starve_hit) begin
            sel_idx = starve_idx;
        end else if (sel_store_hit) begin
            sel_idx = store_idx;
        end else begin
            sel_idx = load_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && !issue_lock) begin
                    load_en = 1'b1;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (fire) begin
                    if (sel_valid && !issue_lock) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (is_store_q && sb_full) begin
                    // A store stuck behind a full store buffer would block every load.
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                idx_q      <= sel_idx;
                is_store_q <= entry_is_store[sel_idx];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MEM_IQ_NUM; i++) begin
            wait_cnt_d[i] = wait_cnt[i];
            if (entry_alloc[i]) begin
                wait_cnt_d[i] = '0;
            end else if (load_en && (sel_idx == MEM_IQ_WIDTH'(i))) begin
                wait_cnt_d[i] = '0;
            end else if (offer_valid && (idx_q == MEM_IQ_WIDTH'(i))) begin
                wait_cnt_d[i] = wait_cnt[i];
            end else if (entry_ready[i] && (wait_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
                wait_cnt_d[i] = wait_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_iq_issue_scheduler.sv
// tb/tb_mem_iq_issue_scheduler.sv - directed self-checking bench for mem_iq_issue_scheduler
module tb_mem_iq_issue_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] entry_alloc;
    logic [7:0] entry_ready;
    logic [7:0] entry_is_store;
    logic       sb_full;
    logic       issue_lock;

    int checks   = 0;
    int failures = 0;

    mem_iq_issue_scheduler_if #(.MEM_IQ_WIDTH(3)) issue ();

    mem_iq_issue_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .entry_alloc    (entry_alloc),
        .entry_ready    (entry_ready),
        .entry_is_store (entry_is_store),
        .sb_full        (sb_full),
        .issue_lock     (issue_lock),
        .issue          (issue.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        flush             = 1'b0;
        entry_alloc       = '0;
        entry_ready       = 8'hFF;
        entry_is_store    = '0;
        sb_full           = 1'b0;
        issue_lock        = 1'b0;
        issue.issue_ready = 1'b0;

        tick();
        tick();
        chk("rst_valid", 32'(issue.issue_valid), 32'd0);
        chk("rst_cnt", dut.wait_cnt, 32'd0);
        rst         = 1'b0;
        entry_ready = '0;
        tick();

        // store priority: load 0, stores 3 and 6
        entry_ready       = 8'b0100_1001;
        entry_is_store    = 8'b0100_1000;
        issue.issue_ready = 1'b1;
        tick();
        chk("prio_v1", 32'(issue.issue_valid), 32'd1);
        chk("prio_idx1", 32'(issue.issue_idx), 32'd3);
        chk("prio_st1", 32'(issue.issue_is_store), 32'd1);
        tick();
        chk("prio_idx2", 32'(issue.issue_idx), 32'd6);
        entry_ready = 8'b0100_0001;
        tick();
        chk("prio_idx3", 32'(issue.issue_idx), 32'd0);
        chk("prio_st3", 32'(issue.issue_is_store), 32'd0);
        entry_ready = 8'b0000_0001;
        tick();
        chk("prio_drain", 32'(issue.issue_valid), 32'd0);
        entry_ready = '0;
        do_flush();

        // hold while stalled, then switch to entry 4
        entry_is_store    = '0;
        entry_ready       = 8'b0000_0100;
        issue.issue_ready = 1'b0;
        tick();
        chk("hold_idx0", 32'(issue.issue_idx), 32'd2);
        entry_ready = 8'b0001_0100;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_v", 32'(issue.issue_valid), 32'd1);
        chk("hold_idx", 32'(issue.issue_idx), 32'd2);
        issue.issue_ready = 1'b1;
        tick();
        chk("hold_next", 32'(issue.issue_idx), 32'd4);
        issue.issue_ready = 1'b0;
        entry_ready       = '0;
        do_flush();

        // flush while offering idx 5
        entry_ready = 8'b0010_0000;
        tick();
        chk("fl_idx", 32'(issue.issue_idx), 32'd5);
        entry_ready = 8'b0010_0010;
        tick();
        tick();
        chk("fl_cnt1", 32'(dut.wait_cnt[1]), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(issue.issue_valid), 32'd0);
        chk("fl_cnt", dut.wait_cnt, 32'd0);
        entry_ready = '0;
        tick();

        // starvation: load 1 against a constant stream of stores 2..7
        do_flush();
        entry_ready       = 8'b1111_1110;
        entry_is_store    = 8'b1111_1100;
        issue.issue_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("starve_st%0d", k), 32'(issue.issue_is_store), 32'd1);
        end
        chk("starve_cnt", 32'(dut.wait_cnt[1]), 32'd12);
        tick();
        chk("starve_idx", 32'(issue.issue_idx), 32'd1);
        chk("starve_ld", 32'(issue.issue_is_store), 32'd0);
        issue.issue_ready = 1'b0;
        entry_ready       = '0;
        do_flush();

        // sb_full withdraws a held store, loads still flow
        entry_ready    = 8'b0010_1000;
        entry_is_store = 8'b0000_1000;
        tick();
        chk("sb_idx3", 32'(issue.issue_idx), 32'd3);
        sb_full = 1'b1;
        tick();
        chk("sb_withdraw", 32'(issue.issue_valid), 32'd0);
        tick();
        chk("sb_idx5", 32'(issue.issue_idx), 32'd5);
        chk("sb_ld5", 32'(issue.issue_is_store), 32'd0);
        issue.issue_ready = 1'b1;
        tick();
        entry_ready = 8'b0000_1000;
        chk("sb_nostore1", 32'(issue.issue_valid), 32'd0);
        tick();
        chk("sb_nostore2", 32'(issue.issue_valid), 32'd0);
        sb_full           = 1'b0;
        issue.issue_ready = 1'b0;
        tick();
        chk("sb_resume_v", 32'(issue.issue_valid), 32'd1);
        chk("sb_resume_idx", 32'(issue.issue_idx), 32'd3);
        entry_ready    = '0;
        entry_is_store = '0;
        do_flush();

        // issue_lock blocks loading but counters keep aging
        entry_ready = 8'b0000_0001;
        issue_lock  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("lock_v%0d", k), 32'(issue.issue_valid), 32'd0);
        end
        chk("lock_cnt0", 32'(dut.wait_cnt[0]), 32'd3);
        issue_lock = 1'b0;
        tick();
        chk("lock_v", 32'(issue.issue_valid), 32'd1);
        chk("lock_idx", 32'(issue.issue_idx), 32'd0);
        chk("lock_cnt_clr", 32'(dut.wait_cnt[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
